// File: rtl/noc_local_inject_arbiter_pkg.sv
// Shared definitions for the NoC local-port inject arbiter.
// State encodings and counter width used by the top and its tests.
package noc_local_inject_arbiter_pkg;

  localparam int NOC_DATA_W = 32;
  localparam int PKT_CNT_W  = 16;

  typedef enum logic {
    NOC_ARB_IDLE   = 1'b0,
    NOC_ARB_LOCKED = 1'b1
  } noc_arb_state_e;

endpackage

// File: rtl/noc_local_inject_arbiter_rr.sv
// Combinational round-robin pick: first set request at or after ptr.
// Kept generic so router VC arbitration can reuse it.
module noc_local_inject_arbiter_rr #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any
);

  logic [IDX_W-1:0] j;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    j         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (!any && req[j]) begin
        grant[j]  = 1'b1;
        grant_idx = j;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/noc_local_inject_arbiter.sv
// Packet-granular round-robin sharing of one router local input port.
// Holds the arbitration FSM, round-robin pointer and one output flit stage.
module noc_local_inject_arbiter
  import noc_local_inject_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = NOC_DATA_W
) (
  input  logic                        noc_clk,
  input  logic                        noc_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_W-1:0]   req_flit,
  input  logic [NUM_REQ-1:0]          req_is_header,
  input  logic [NUM_REQ-1:0]          req_is_tail,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_flit,
  output logic                        out_is_header,
  output logic                        out_is_tail,
  output logic [$clog2(NUM_REQ)-1:0]  owner,
  output logic                        busy,
  output logic                        protocol_err,
  output logic [PKT_CNT_W-1:0]        pkt_count
);

  localparam int IDX_W = $clog2(NUM_REQ);

  noc_arb_state_e state;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   arb_idx;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] arb_grant;
  logic [NUM_REQ-1:0] lock_grant;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] fire;
  logic               arb_any;
  logic               load_en;
  logic               xfer;
  logic               sel_hdr;
  logic               sel_tail;
  logic               gap;
  logic [DATA_W-1:0]  flit_arr [NUM_REQ];

  assign cand = req_valid & req_is_header;

  noc_local_inject_arbiter_rr #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req       (cand),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      flit_arr[i] = req_flit[i*DATA_W +: DATA_W];
    end
  end

  assign lock_grant = NUM_REQ'(1) << owner;

  // gap blocks arbitration for the cycle right after a locked tail
  always_comb begin
    grant   = '0;
    sel_idx = owner;
    unique case (1'b1)
      (state == NOC_ARB_LOCKED): begin
        grant = lock_grant;
      end
      (state == NOC_ARB_IDLE && !gap && arb_any): begin
        grant   = arb_grant;
        sel_idx = arb_idx;
      end
      default: ;
    endcase
  end

  assign load_en   = !out_valid | out_ready;
  assign req_ready = (load_en && !noc_rst) ? grant : '0;
  assign fire      = req_valid & req_ready;
  assign xfer      = |fire;
  assign sel_hdr   = req_is_header[sel_idx];
  assign sel_tail  = req_is_tail[sel_idx];
  assign busy      = (state == NOC_ARB_LOCKED);

  assign ptr_nxt = (arb_idx == IDX_W'(NUM_REQ - 1)) ?
                   '0 : arb_idx + 1'b1;

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state         <= NOC_ARB_IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      gap           <= 1'b0;
      out_valid     <= 1'b0;
      out_flit      <= '0;
      out_is_header <= 1'b0;
      out_is_tail   <= 1'b0;
      protocol_err  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      if (load_en) begin
        out_valid <= xfer;
        if (xfer) begin
          out_flit      <= flit_arr[sel_idx];
          out_is_header <= sel_hdr;
          out_is_tail   <= sel_tail;
        end
      end
      gap <= 1'b0;
      if (state == NOC_ARB_IDLE &&
          |(req_valid & ~req_is_header)) begin
        protocol_err <= 1'b1;
      end
      unique case (state)
        NOC_ARB_IDLE: begin
          if (xfer) begin
            owner  <= arb_idx;
            rr_ptr <= ptr_nxt;
            if (sel_tail) begin
              pkt_count <= pkt_count + 1'b1;
            end else begin
              state <= NOC_ARB_LOCKED;
            end
          end
        end
        NOC_ARB_LOCKED: begin
          if (xfer && sel_tail) begin
            state     <= NOC_ARB_IDLE;
            gap       <= 1'b1;
            pkt_count <= pkt_count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
